// File: rtl/cellrv32_npu_package.sv
// rtl/cellrv32_npu_package.sv - NPU instruction formats, opcodes and dispatcher types
// Instruction words are 80 bits; LOAD_WEIGHT reinterprets the same word with a wider address field.
package cellrv32_npu_package;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] src_addr;
    logic [23:0] dst_addr;
    logic [15:0] len;
    logic [7:0]  flags;
  } instruction_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [39:0] wei_addr;
    logic [15:0] len;
    logic [15:0] rsvd;
  } weight_instruction_t;

  typedef enum logic [3:0] {
    ACT_LINEAR     = 4'h0,
    ACT_RELU       = 4'h1,
    ACT_RELU6      = 4'h2,
    ACT_LEAKY_RELU = 4'h3,
    ACT_ELU        = 4'h4,
    ACT_SELU       = 4'h5,
    ACT_GELU       = 4'h6,
    ACT_SIGMOID    = 4'h7,
    ACT_TANH       = 4'h8,
    ACT_SWISH      = 4'h9,
    ACT_SOFTPLUS   = 4'hA
  } activation_type_t;

  localparam logic [7:0] OPC_NOP         = 8'h00;
  localparam logic [7:0] OPC_LOAD_WEIGHT = 8'h08;
  localparam logic [7:0] OPC_MATMUL      = 8'h20;
  localparam logic [7:0] OPC_ACTIVATE    = 8'h80;
  localparam logic [7:0] OPC_SYNC        = 8'hFF;
  localparam logic [3:0] ACT_TYPE_LAST   = 4'hA;

  typedef enum logic [1:0] {
    DISP_IDLE,
    DISP_ISSUE,
    DISP_SYNC_WAIT
  } disp_state_t;

  typedef enum logic [1:0] {
    UNIT_WEI,
    UNIT_MMU,
    UNIT_ACT
  } unit_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WEI,
    CLS_MMU,
    CLS_ACT,
    CLS_SYNC,
    CLS_ILLEGAL
  } instr_class_t;

  function automatic instr_class_t decode_opcode(input logic [7:0] opc);
    instr_class_t cls;
    if (opc == OPC_NOP)                  cls = CLS_NOP;
    else if (opc == OPC_LOAD_WEIGHT)     cls = CLS_WEI;
    else if (opc == OPC_MATMUL)          cls = CLS_MMU;
    else if (opc == OPC_SYNC)            cls = CLS_SYNC;
    else if (opc[7:4] == OPC_ACTIVATE[7:4] && opc[3:0] <= ACT_TYPE_LAST)
                                         cls = CLS_ACT;
    else                                 cls = CLS_ILLEGAL;
    return cls;
  endfunction

endpackage

// File: rtl/cellrv32_npu_instr_fifo.sv
// rtl/cellrv32_npu_instr_fifo.sv - instruction queue with first-word-fall-through head
// Pointers carry an extra wrap bit so full and empty are distinguishable at equal indices.
module cellrv32_npu_instr_fifo #(
  parameter int  DEPTH  = 4,
  parameter type data_t = logic [7:0]
) (
  input  logic  clk_i,
  input  logic  rstn_i,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);

  data_t       mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_o  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i && !empty_o) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/cellrv32_npu_instr_dispatcher.sv
// rtl/cellrv32_npu_instr_dispatcher.sv - queues host instructions and issues them to weight/MMU/activation units
// Only one unit handshake is open at a time; per-unit busy flags enforce data dependencies.
module cellrv32_npu_instr_dispatcher
  import cellrv32_npu_package::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                instr_valid_i,
  input  instruction_t        instr_i,
  output logic                instr_ready_o,
  output logic                wei_valid_o,
  output weight_instruction_t wei_instr_o,
  input  logic                wei_ready_i,
  input  logic                wei_done_i,
  output logic                mmu_valid_o,
  output instruction_t        mmu_instr_o,
  input  logic                mmu_ready_i,
  input  logic                mmu_done_i,
  output logic                act_valid_o,
  output instruction_t        act_instr_o,
  output activation_type_t    act_type_o,
  input  logic                act_ready_i,
  input  logic                act_done_i,
  output logic                sync_o,
  output logic                err_o,
  output logic                busy_o
);

  instruction_t head;
  logic         q_full;
  logic         q_empty;
  logic         q_push;
  logic         q_pop;

  disp_state_t  state, state_n;
  unit_t        unit, unit_n;
  instr_class_t head_cls;
  logic         wei_busy, mmu_busy, act_busy;
  logic         load_wei, load_mmu, load_act;
  logic         err_n, sync_n;
  logic         issue_ready;
  logic         accept;

  // Ready is forced low while in reset so every output reads 0 until release.
  assign instr_ready_o = rstn_i & ~q_full;
  assign q_push        = instr_valid_i & instr_ready_o;
  assign head_cls      = decode_opcode(head.opcode);

  cellrv32_npu_instr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (instruction_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (q_push),
    .data_i  (instr_i),
    .pop_i   (q_pop),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    case (unit)
      UNIT_WEI: issue_ready = wei_ready_i;
      UNIT_MMU: issue_ready = mmu_ready_i;
      default:  issue_ready = act_ready_i;
    endcase
  end

  always_comb begin
    state_n  = state;
    unit_n   = unit;
    q_pop    = 1'b0;
    load_wei = 1'b0;
    load_mmu = 1'b0;
    load_act = 1'b0;
    err_n    = 1'b0;
    sync_n   = 1'b0;
    case (state)
      DISP_IDLE: begin
        if (!q_empty) begin
          case (head_cls)
            CLS_NOP: q_pop = 1'b1;
            CLS_ILLEGAL: begin
              q_pop = 1'b1;
              err_n = 1'b1;
            end
            CLS_WEI: begin
              if (!wei_busy) begin
                q_pop    = 1'b1;
                load_wei = 1'b1;
                unit_n   = UNIT_WEI;
                state_n  = DISP_ISSUE;
              end
            end
            CLS_MMU: begin
              if (!wei_busy && !mmu_busy) begin
                q_pop    = 1'b1;
                load_mmu = 1'b1;
                unit_n   = UNIT_MMU;
                state_n  = DISP_ISSUE;
              end
            end
            CLS_ACT: begin
              if (!mmu_busy && !act_busy) begin
                q_pop    = 1'b1;
                load_act = 1'b1;
                unit_n   = UNIT_ACT;
                state_n  = DISP_ISSUE;
              end
            end
            CLS_SYNC: begin
              q_pop   = 1'b1;
              state_n = DISP_SYNC_WAIT;
            end
            default: ;
          endcase
        end
      end
      DISP_ISSUE: begin
        if (issue_ready) state_n = DISP_IDLE;
      end
      DISP_SYNC_WAIT: begin
        if (!wei_busy && !mmu_busy && !act_busy) begin
          sync_n  = 1'b1;
          state_n = DISP_IDLE;
        end
      end
      default: state_n = DISP_IDLE;
    endcase
  end

  assign accept      = (state == DISP_ISSUE) && issue_ready;
  assign wei_valid_o = (state == DISP_ISSUE) && (unit == UNIT_WEI);
  assign mmu_valid_o = (state == DISP_ISSUE) && (unit == UNIT_MMU);
  assign act_valid_o = (state == DISP_ISSUE) && (unit == UNIT_ACT);
  assign busy_o      = !q_empty || (state != DISP_IDLE) || wei_busy || mmu_busy || act_busy;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= DISP_IDLE;
      unit        <= UNIT_WEI;
      wei_instr_o <= '0;
      mmu_instr_o <= '0;
      act_instr_o <= '0;
      act_type_o  <= ACT_LINEAR;
      err_o       <= 1'b0;
      sync_o      <= 1'b0;
      wei_busy    <= 1'b0;
      mmu_busy    <= 1'b0;
      act_busy    <= 1'b0;
    end else begin
      state  <= state_n;
      unit   <= unit_n;
      err_o  <= err_n;
      sync_o <= sync_n;
      if (load_wei) wei_instr_o <= weight_instruction_t'(head);
      if (load_mmu) mmu_instr_o <= head;
      if (load_act) begin
        act_instr_o <= head;
        act_type_o  <= activation_type_t'(head.opcode[3:0]);
      end
      // A fresh accept wins over a coincident done on the same unit.
      wei_busy <= (accept && unit == UNIT_WEI) || (wei_busy && !wei_done_i);
      mmu_busy <= (accept && unit == UNIT_MMU) || (mmu_busy && !mmu_done_i);
      act_busy <= (accept && unit == UNIT_ACT) || (act_busy && !act_done_i);
    end
  end

endmodule

// File: tb/tb_cellrv32_npu_instr_dispatcher.sv
// tb/tb_cellrv32_npu_instr_dispatcher.sv - directed self-checking bench for the NPU instruction dispatcher
module tb_cellrv32_npu_instr_dispatcher;
  import cellrv32_npu_package::*;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                instr_valid = 1'b0;
  instruction_t        instr = '0;
  logic                instr_ready;
  logic                wei_valid, mmu_valid, act_valid;
  weight_instruction_t wei_instr;
  instruction_t        mmu_instr, act_instr;
  activation_type_t    act_type;
  logic                wei_ready = 1'b0, wei_done = 1'b0;
  logic                mmu_ready = 1'b0, mmu_done = 1'b0;
  logic                act_ready = 1'b0, act_done = 1'b0;
  logic                sync_p, err_p, busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  cellrv32_npu_instr_dispatcher #(.FIFO_DEPTH(4)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .instr_valid_i (instr_valid),
    .instr_i       (instr),
    .instr_ready_o (instr_ready),
    .wei_valid_o   (wei_valid),
    .wei_instr_o   (wei_instr),
    .wei_ready_i   (wei_ready),
    .wei_done_i    (wei_done),
    .mmu_valid_o   (mmu_valid),
    .mmu_instr_o   (mmu_instr),
    .mmu_ready_i   (mmu_ready),
    .mmu_done_i    (mmu_done),
    .act_valid_o   (act_valid),
    .act_instr_o   (act_instr),
    .act_type_o    (act_type),
    .act_ready_i   (act_ready),
    .act_done_i    (act_done),
    .sync_o        (sync_p),
    .err_o         (err_p),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input instruction_t t);
    instr       = t;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    wei_ready = r;
    mmu_ready = r;
    act_ready = r;
  endtask

  function automatic instruction_t mk(input logic [7:0] opc, input logic [23:0] src);
    instruction_t t;
    t.opcode   = opc;
    t.src_addr = src;
    t.dst_addr = 24'hABC000 ^ src;
    t.len      = 16'h0040;
    t.flags    = 8'h5A;
    return t;
  endfunction

  function automatic instruction_t mk_lw(input logic [39:0] addr, input logic [15:0] len);
    weight_instruction_t w;
    logic [79:0]         bits;
    w.opcode   = OPC_LOAD_WEIGHT;
    w.wei_addr = addr;
    w.len      = len;
    w.rsvd     = 16'h0000;
    bits       = w;
    return bits;
  endfunction

  instruction_t seq [3];
  int  mmu_iss, act_iss, sync_cnt;
  logic early, act_done_given;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_valids", {wei_valid, mmu_valid, act_valid}, 3'b000);
    chk("rst_pulses", {sync_p, err_p, busy}, 3'b000);
    rstn = 1'b1;
    tick();
    chk("rel_ready", instr_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);

    // single LOAD_WEIGHT with ready held high
    set_ready(1'b1);
    push1(mk_lw(40'h123456789A, 16'd16));
    chk("t1_valid_c1", wei_valid, 1'b0);
    chk("t1_busy_q", busy, 1'b1);
    tick();
    chk("t1_valid_c2", wei_valid, 1'b1);
    chk("t1_payload", wei_instr, mk_lw(40'h123456789A, 16'd16));
    chk("t1_others", {mmu_valid, act_valid}, 2'b00);
    tick();
    chk("t1_valid_c3", wei_valid, 1'b0);
    chk("t1_busy_unit", busy, 1'b1);
    wei_done = 1'b1;
    tick();
    wei_done = 1'b0;
    chk("t1_busy_clr", busy, 1'b0);

    // held valid while ready low, then done coincident with accept
    wei_ready = 1'b0;
    push1(mk_lw(40'h0000000042, 16'd4));
    tick();
    tick();
    chk("t1b_hold_valid", wei_valid, 1'b1);
    chk("t1b_hold_data", wei_instr, mk_lw(40'h0000000042, 16'd4));
    wei_ready = 1'b1;
    wei_done  = 1'b1;
    tick();
    wei_done = 1'b0;
    chk("t1b_accept", wei_valid, 1'b0);
    chk("t1b_busy_kept", busy, 1'b1);
    mmu_done = 1'b1;
    tick();
    mmu_done = 1'b0;
    chk("t1b_idle_done_ignored", busy, 1'b1);
    wei_done = 1'b1;
    tick();
    wei_done = 1'b0;
    chk("t1b_busy_clr", busy, 1'b0);

    // MATMUL waits for the weight unit
    instr = mk_lw(40'h0000000001, 16'd8);
    instr_valid = 1'b1;
    tick();
    instr = mk(OPC_MATMUL, 24'h000111);
    tick();
    instr_valid = 1'b0;
    chk("t2_wei_valid", wei_valid, 1'b1);
    tick();
    early = 1'b0;
    repeat (10) begin
      tick();
      if (mmu_valid) early = 1'b1;
    end
    wei_done = 1'b1;
    tick();
    wei_done = 1'b0;
    if (mmu_valid) early = 1'b1;
    chk("t2_mmu_not_early", early, 1'b0);
    tick();
    chk("t2_mmu_valid", mmu_valid, 1'b1);
    chk("t2_mmu_payload", mmu_instr, mk(OPC_MATMUL, 24'h000111));
    tick();
    mmu_done = 1'b1;
    tick();
    mmu_done = 1'b0;
    chk("t2_busy_clr", busy, 1'b0);

    // queue fills while the weight unit is busy; order preserved on drain
    push1(mk_lw(40'h00000000A0, 16'd1));
    tick();
    tick();
    set_ready(1'b0);
    for (int i = 1; i <= 5; i++) begin
      instr = mk_lw(40'hB0 + 40'(i), 16'(i));
      instr_valid = 1'b1;
      chk($sformatf("t3_ready_%0d", i), instr_ready, (i <= 4) ? 1'b1 : 1'b0);
      if (i <= 4) tick();
    end
    tick();
    chk("t3_still_full", instr_ready, 1'b0);
    wei_done = 1'b1;
    tick();
    wei_done = 1'b0;
    chk("t3_full_before_pop", instr_ready, 1'b0);
    wei_ready = 1'b1;
    tick();
    chk("t3_ready_after_pop", instr_ready, 1'b1);
    chk("t3_valid_1", wei_valid, 1'b1);
    chk("t3_payload_1", wei_instr, mk_lw(40'hB1, 16'd1));
    tick();
    instr_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      wei_done = 1'b1;
      tick();
      wei_done = 1'b0;
      tick();
      chk($sformatf("t3_valid_%0d", k), wei_valid, 1'b1);
      chk($sformatf("t3_payload_%0d", k), wei_instr, mk_lw(40'hB0 + 40'(k), 16'(k)));
      tick();
    end
    wei_done = 1'b1;
    tick();
    wei_done = 1'b0;
    chk("t3_busy_clr", busy, 1'b0);

    // activation type decode, illegal opcode, NOP
    set_ready(1'b1);
    push1(mk(8'h85, 24'h000222));
    tick();
    chk("t4_act_valid", act_valid, 1'b1);
    chk("t4_act_type", act_type, ACT_SELU);
    chk("t4_act_payload", act_instr, mk(8'h85, 24'h000222));
    tick();
    act_done = 1'b1;
    tick();
    act_done = 1'b0;
    instr = mk(8'h42, 24'h0);
    instr_valid = 1'b1;
    tick();
    instr = mk(OPC_MATMUL, 24'h000333);
    tick();
    instr_valid = 1'b0;
    chk("t4_err_pulse", err_p, 1'b1);
    chk("t4_err_no_valid", {wei_valid, mmu_valid, act_valid}, 3'b000);
    tick();
    chk("t4_err_end", err_p, 1'b0);
    chk("t4_next_proceeds", mmu_valid, 1'b1);
    chk("t4_next_payload", mmu_instr, mk(OPC_MATMUL, 24'h000333));
    tick();
    mmu_done = 1'b1;
    tick();
    mmu_done = 1'b0;
    push1(mk(OPC_NOP, 24'h0));
    chk("t4_nop_queued", busy, 1'b1);
    tick();
    chk("t4_nop_quiet", {wei_valid, mmu_valid, act_valid, err_p}, 4'b0000);
    chk("t4_nop_busy", busy, 1'b0);

    // MATMUL, ACTIVATE, SYNC with done 20 cycles after each issue
    seq[0] = mk(OPC_MATMUL, 24'h000444);
    seq[1] = mk(8'h81, 24'h000555);
    seq[2] = mk(OPC_SYNC, 24'h0);
    mmu_iss = -1;
    act_iss = -1;
    sync_cnt = 0;
    early = 1'b0;
    act_done_given = 1'b0;
    for (int c = 0; c < 120; c++) begin
      instr_valid = (c < 3);
      if (c < 3) instr = seq[c];
      mmu_done = (mmu_iss >= 0) && (c == mmu_iss + 20);
      act_done = (act_iss >= 0) && (c == act_iss + 20);
      if (act_done) act_done_given = 1'b1;
      if (mmu_valid && mmu_ready) mmu_iss = c;
      if (act_valid && act_ready) act_iss = c;
      tick();
      if (sync_p) begin
        sync_cnt++;
        if (!act_done_given) early = 1'b1;
      end
    end
    instr_valid = 1'b0;
    mmu_done = 1'b0;
    act_done = 1'b0;
    chk("t5_mmu_issued", mmu_iss >= 0, 1'b1);
    chk("t5_act_after_mmu_done", act_iss > mmu_iss + 20, 1'b1);
    chk("t5_sync_once", sync_cnt, 1);
    chk("t5_sync_not_early", early, 1'b0);
    chk("t5_idle", {busy, sync_p}, 2'b00);

    // reset with an open MMU handshake and three entries queued
    set_ready(1'b0);
    push1(mk(OPC_MATMUL, 24'h000666));
    instr = mk_lw(40'h77, 16'd7);
    instr_valid = 1'b1;
    tick();
    instr = mk(8'h82, 24'h000888);
    tick();
    instr = mk(OPC_NOP, 24'h0);
    tick();
    instr_valid = 1'b0;
    chk("t6_mmu_open", mmu_valid, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_valids", {wei_valid, mmu_valid, act_valid}, 3'b000);
    chk("t6_rst_flags", {instr_ready, sync_p, err_p, busy}, 4'b0000);
    chk("t6_rst_payload", mmu_instr, 80'h0);
    #2;
    rstn = 1'b1;
    set_ready(1'b1);
    tick();
    chk("t6_rel_ready", instr_ready, 1'b1);
    chk("t6_rel_busy", busy, 1'b0);
    repeat (3) tick();
    chk("t6_queue_empty", {wei_valid, mmu_valid, act_valid, busy}, 4'b0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cellrv32_npu_instr_dispatcher.md
CELLRV32_NPU_INSTR_DISPATCHER -- requirements
Module: cellrv32_npu_instr_dispatcher

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, instruction queue depth (power of two, >=2).
REQ-002 SHALL have port clk_i, input, 1, single clock for all state.
REQ-003 SHALL have port rstn_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port instr_valid_i, input, 1, host instruction offered.
REQ-005 SHALL have port instr_i, input, instruction_t (80), host instruction word.
REQ-006 SHALL have port instr_ready_o, output, 1, queue can accept.
REQ-007 SHALL have ports wei_valid_o out 1, wei_instr_o out weight_instruction_t (80), wei_ready_i in 1, wei_done_i in 1, weight-load unit channel.
REQ-008 SHALL have ports mmu_valid_o out 1, mmu_instr_o out instruction_t, mmu_ready_i in 1, mmu_done_i in 1, matrix-multiply unit channel.
REQ-009 SHALL have ports act_valid_o out 1, act_instr_o out instruction_t, act_type_o out activation_type_t, act_ready_i in 1, act_done_i in 1, activation unit channel.
REQ-010 SHALL have ports sync_o out 1 (SYNCHRONIZE completed pulse), err_o out 1 (illegal-opcode pulse), busy_o out 1 (work pending).

Function
REQ-011 Queue push SHALL occur on instr_valid_i & instr_ready_o; instr_ready_o = queue not full, independent of a same-cycle pop.
REQ-012 Opcode decode SHALL be: 0x00 NOP; 0x08 LOAD_WEIGHT (word reinterpreted as weight_instruction_t); 0x20 MATMUL; 0x80..0x8A ACTIVATE with opcode[3:0] as activation_type_t; 0xFF SYNCHRONIZE; anything else illegal.
REQ-013 FSM states SHALL be IDLE, ISSUE, SYNC_WAIT.
REQ-014 In IDLE with queue non-empty, the head SHALL be popped and handled the same cycle when its dependency rule is met; otherwise the head SHALL stay.
REQ-015 Dependency rules SHALL be: LOAD_WEIGHT needs weight unit idle; MATMUL needs weight and MMU idle; ACTIVATE needs MMU and activation idle; NOP and illegal need none.
REQ-016 On popping LOAD_WEIGHT/MATMUL/ACTIVATE, the matching *_instr_o (and act_type_o) SHALL be registered, *_valid_o SHALL assert next cycle, and FSM SHALL enter ISSUE.
REQ-017 In ISSUE, valid and payload SHALL hold stable until the matching ready_i is high; on that edge valid deasserts, the unit's busy flag sets and FSM returns to IDLE.
REQ-018 Minimum issue rate SHALL be one dispatched instruction per 2 cycles.
REQ-019 A unit busy flag SHALL clear on its done_i; done_i on an idle unit SHALL be ignored; done_i coincident with a new accept on the same unit SHALL leave busy set.
REQ-020 NOP SHALL pop with no output; illegal opcode SHALL pop and pulse err_o for exactly one cycle the next cycle.
REQ-021 SYNCHRONIZE SHALL pop and enter SYNC_WAIT; when all three busy flags are clear, sync_o SHALL pulse one cycle and FSM SHALL return to IDLE.
REQ-022 At most one *_valid_o SHALL be high in any cycle.
REQ-023 busy_o SHALL equal queue non-empty OR FSM != IDLE OR any unit busy flag set.

Reset
REQ-024 On rstn_i low, asynchronously: queue empty, FSM IDLE, busy flags clear, every output 0 except instr_ready_o, which SHALL be 1 once reset is released.
REQ-025 Reset mid-operation SHALL discard queued and in-flight instructions; no done_i is expected afterwards.

Structure
REQ-026 Opcode constants (OPC_NOP, OPC_LOAD_WEIGHT, OPC_MATMUL, OPC_ACTIVATE, OPC_SYNC) SHALL be added to cellrv32_npu_package alongside instruction_t.
REQ-027 The queue SHALL be one sub-module, cellrv32_npu_instr_fifo, parameterised by depth and data type.

Verification
REQ-028 Push LOAD_WEIGHT(wei_addr=0x123456789A, len=16) with ready_i held high -> wei_valid_o high exactly 1 cycle, 2 cycles after push, payload bit-exact.
REQ-029 LOAD_WEIGHT then MATMUL; wei_done_i 10 cycles after issue -> mmu_valid_o not asserted before the cycle after wei_done_i.
REQ-030 Push 5 instructions back-to-back with FIFO_DEPTH=4 and all ready_i low -> instr_ready_o drops after the 4th accepted word; no entry lost or reordered.
REQ-031 Opcode 0x85 -> act_type_o=SELU; opcode 0x42 -> err_o one-cycle pulse, no valid asserted, next instruction proceeds.
REQ-032 MATMUL, ACTIVATE, SYNCHRONIZE, with done_i returned 20 cycles after each issue -> sync_o pulses once, only after act_done_i, then busy_o=0.
REQ-033 Assert rstn_i low while mmu_valid_o is high with 3 entries queued -> all outputs 0 immediately, queue empty after release.
